// File: rtl/hazard_tracker_if.sv
// D-stage decode-to-hazard-unit bundle: decoded operand usage in, stall/forward controls out.
interface hazard_tracker_if;
  logic       tuse_rs0;
  logic       tuse_rs1;
  logic       tuse_rt0;
  logic       tuse_rt1;
  logic       tuse_rt2;
  logic [1:0] res_d;
  logic [4:0] a1_d;
  logic [4:0] a2_d;
  logic [4:0] a3_d;
  logic       stall;
  logic       clr_e;
  logic [1:0] fwd_rs_d;
  logic [1:0] fwd_rt_d;
  logic [1:0] fwd_rs_e;
  logic [1:0] fwd_rt_e;
  logic       fwd_rt_m;

  modport master (
    output tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2,
    output res_d, a1_d, a2_d, a3_d,
    input  stall, clr_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
  );

  modport slave (
    input  tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2,
    input  res_d, a1_d, a2_d, a3_d,
    output stall, clr_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
  );
endinterface

// File: rtl/hazard_tracker.sv
// Tracks destination/Tnew of in-flight producers in E, M, W and derives the
// D-stage stall plus the D/E/M forwarding selects for the 5-stage MIPS pipe.
module hazard_tracker #(
  parameter logic [1:0] TNEW_ALU = 2'd1,
  parameter logic [1:0] TNEW_DM  = 2'd2,
  parameter logic [1:0] TNEW_PC  = 2'd0
) (
  input logic             clk,
  input logic             reset,
  hazard_tracker_if.slave hz
);

  localparam logic [1:0] RES_NW  = 2'b00;
  localparam logic [1:0] RES_ALU = 2'b01;
  localparam logic [1:0] RES_DM  = 2'b10;
  localparam logic [1:0] RES_PC  = 2'b11;

  typedef struct packed {
    logic [1:0] res;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [4:0] a1;
    logic [4:0] a2;
  } e_rec_t;

  // M keeps only rt: nothing downstream of E looks at its rs address.
  typedef struct packed {
    logic [1:0] res;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [4:0] a2;
  } m_rec_t;

  typedef struct packed {
    logic [1:0] res;
    logic [4:0] a3;
    logic [1:0] tnew;
  } w_rec_t;

  e_rec_t e_r;
  m_rec_t m_r;
  w_rec_t w_r;

  logic       rs_used;
  logic [1:0] rs_tuse;
  logic       rt_used;
  logic [1:0] rt_tuse;
  logic       stall_s;
  logic [1:0] fwd_rs_d_s;
  logic [1:0] fwd_rt_d_s;
  logic [1:0] fwd_rs_e_s;
  logic [1:0] fwd_rt_e_s;
  logic       fwd_rt_m_s;

  function automatic logic [1:0] tnew_of(input logic [1:0] res);
    logic [1:0] t;
    case (res)
      RES_ALU: t = TNEW_ALU;
      RES_DM:  t = TNEW_DM;
      RES_PC:  t = TNEW_PC;
      RES_NW:  t = 2'd0;
      default: t = 2'd0;
    endcase
    return t;
  endfunction

  // A record matches only when it really writes a non-$0 register equal to x.
  function automatic logic hits(input logic [1:0] res, input logic [4:0] a3,
                                input logic [4:0] x);
    return (res != RES_NW) && (a3 != 5'd0) && (x != 5'd0) && (a3 == x);
  endfunction

  function automatic logic op_stall(input logic used, input logic [1:0] tuse,
                                    input logic [4:0] x, input e_rec_t e,
                                    input m_rec_t m);
    logic s;
    if (!used) begin
      s = 1'b0;
    end else if (hits(e.res, e.a3, x)) begin
      s = (e.tnew > tuse);
    end else if (hits(m.res, m.a3, x)) begin
      s = (m.tnew > tuse);
    end else begin
      s = 1'b0;
    end
    return s;
  endfunction

  // Nearest producer decides; a not-yet-ready nearest one blocks older copies.
  function automatic logic [1:0] fwd_d(input logic [4:0] x, input e_rec_t e,
                                       input m_rec_t m, input w_rec_t w);
    logic [1:0] sel;
    if (hits(e.res, e.a3, x)) begin
      sel = (e.tnew == 2'd0) ? 2'd1 : 2'd0;
    end else if (hits(m.res, m.a3, x)) begin
      sel = (m.tnew == 2'd0) ? 2'd2 : 2'd0;
    end else if (hits(w.res, w.a3, x)) begin
      sel = (w.tnew == 2'd0) ? 2'd3 : 2'd0;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] x, input m_rec_t m,
                                       input w_rec_t w);
    logic [1:0] sel;
    if (hits(m.res, m.a3, x) && (m.tnew == 2'd0)) begin
      sel = 2'd1;
    end else if (hits(w.res, w.a3, x)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // Decode the earliest stage at which each operand is consumed.
  always_comb begin
    rs_used = hz.tuse_rs0 | hz.tuse_rs1;
    rt_used = hz.tuse_rt0 | hz.tuse_rt1 | hz.tuse_rt2;
    if (hz.tuse_rs0) begin
      rs_tuse = 2'd0;
    end else begin
      rs_tuse = 2'd1;
    end
    if (hz.tuse_rt0) begin
      rt_tuse = 2'd0;
    end else if (hz.tuse_rt1) begin
      rt_tuse = 2'd1;
    end else begin
      rt_tuse = 2'd2;
    end
  end

  // Stall and forwarding selects from the current stage records.
  always_comb begin
    stall_s    = op_stall(rs_used, rs_tuse, hz.a1_d, e_r, m_r) |
                 op_stall(rt_used, rt_tuse, hz.a2_d, e_r, m_r);
    fwd_rs_d_s = fwd_d(hz.a1_d, e_r, m_r, w_r);
    fwd_rt_d_s = fwd_d(hz.a2_d, e_r, m_r, w_r);
    fwd_rs_e_s = fwd_e(e_r.a1, m_r, w_r);
    fwd_rt_e_s = fwd_e(e_r.a2, m_r, w_r);
    fwd_rt_m_s = (m_r.a2 != 5'd0) && hits(w_r.res, w_r.a3, m_r.a2);
  end

  // Advance the stage records; a stall injects a bubble into E.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_r <= '0;
      m_r <= '0;
      w_r <= '0;
    end else begin
      w_r <= '{res: m_r.res, a3: m_r.a3, tnew: 2'd0};
      m_r <= '{res:  e_r.res,
               a3:   e_r.a3,
               tnew: (e_r.tnew == 2'd0) ? 2'd0 : (e_r.tnew - 2'd1),
               a2:   e_r.a2};
      if (stall_s) begin
        e_r <= '0;
      end else begin
        e_r <= '{res:  hz.res_d,
                 a3:   hz.a3_d,
                 tnew: tnew_of(hz.res_d),
                 a1:   hz.a1_d,
                 a2:   hz.a2_d};
      end
    end
  end

  assign hz.stall    = stall_s;
  assign hz.clr_e    = stall_s;
  assign hz.fwd_rs_d = fwd_rs_d_s;
  assign hz.fwd_rt_d = fwd_rt_d_s;
  assign hz.fwd_rs_e = fwd_rs_e_s;
  assign hz.fwd_rt_e = fwd_rt_e_s;
  assign hz.fwd_rt_m = fwd_rt_m_s;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed scoreboard bench for hazard_tracker: instruction sequences in D,
// expected stall/forward vectors queued per cycle and checked on the falling edge.
module tb_hazard_tracker;

  localparam logic [4:0] RS0 = 5'b10000;
  localparam logic [4:0] RS1 = 5'b01000;
  localparam logic [4:0] RT0 = 5'b00100;
  localparam logic [4:0] RT1 = 5'b00010;
  localparam logic [4:0] RT2 = 5'b00001;
  localparam logic [1:0] NW  = 2'b00;
  localparam logic [1:0] ALU = 2'b01;
  localparam logic [1:0] DM  = 2'b10;
  localparam logic [1:0] PC  = 2'b11;

  typedef struct {
    string       tag;
    logic [10:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  hazard_tracker_if hif();

  hazard_tracker dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif.slave)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] tu, input logic [1:0] res,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
    hif.tuse_rs0 = tu[4];
    hif.tuse_rs1 = tu[3];
    hif.tuse_rt0 = tu[2];
    hif.tuse_rt1 = tu[1];
    hif.tuse_rt2 = tu[0];
    hif.res_d    = res;
    hif.a1_d     = a1;
    hif.a2_d     = a2;
    hif.a3_d     = a3;
  endtask

  task automatic expect_out(input string tag, input logic st, input logic [1:0] rsd,
                            input logic [1:0] rtd, input logic [1:0] rse,
                            input logic [1:0] rte, input logic rtm);
    exp_t e;
    e.tag = tag;
    e.vec = {st, st, rsd, rtd, rse, rte, rtm};
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t        e;
    logic [10:0] obs;
    @(negedge clk);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = {hif.stall, hif.clr_e, hif.fwd_rs_d, hif.fwd_rt_d,
             hif.fwd_rs_e, hif.fwd_rt_e, hif.fwd_rt_m};
      checks++;
      assert (obs === e.vec) else begin
        errors++;
        $error("FAIL %s: observed {stall,clr_e,rs_d,rt_d,rs_e,rt_e,rt_m}=%b expected %b",
               e.tag, obs, e.vec);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input string tag, input logic st, input logic [1:0] rsd,
                      input logic [1:0] rtd, input logic [1:0] rse,
                      input logic [1:0] rte, input logic rtm);
    expect_out(tag, st, rsd, rtd, rse, rte, rtm);
    check_now();
    adv();
  endtask

  task automatic flush();
    drive(5'b0, NW, 5'd0, 5'd0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(RS1 | RT1, ALU, 5'd1, 5'd1, 5'd2);
    repeat (2) @(posedge clk);
    #1;
    tick("reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    reset = 1'b0;
    flush();

    // lw $1 ; addu $2,$1,$1
    drive(RS1, DM, 5'd0, 5'd0, 5'd1);
    tick("t1_lw", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive(RS1 | RT1, ALU, 5'd1, 5'd1, 5'd2);
    tick("t1_stall", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick("t1_release", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive(5'b0, NW, 5'd0, 5'd0, 5'd0);
    tick("t1_fwd_e_w", 1'b0, 2'd0, 2'd0, 2'd2, 2'd2, 1'b0);
    flush();

    // lw $1 ; beq $1,$0
    drive(RS1, DM, 5'd0, 5'd0, 5'd1);
    tick("t2_lw", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive(RS0 | RT0, NW, 5'd1, 5'd0, 5'd0);
    tick("t2_stall_a", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick("t2_stall_b", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick("t2_fwd_d_w", 1'b0, 2'd3, 2'd0, 2'd0, 2'd0, 1'b0);
    flush();

    // ori $5 ; sw $5,0($6)
    drive(RS1, ALU, 5'd0, 5'd0, 5'd5);
    tick("t3_ori", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive(RS1 | RT2, NW, 5'd6, 5'd5, 5'd0);
    tick("t3_sw_d", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive(5'b0, NW, 5'd0, 5'd0, 5'd0);
    tick("t3_sw_e", 1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0);
    tick("t3_sw_m", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    flush();

    // jal ; jr $31
    drive(5'b0, PC, 5'd0, 5'd0, 5'd31);
    tick("t4_jal", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive(RS0, NW, 5'd31, 5'd0, 5'd0);
    tick("t4_jr", 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0);
    flush();

    // lw $0 ; addu $2,$0,$0
    drive(RS1, DM, 5'd0, 5'd0, 5'd0);
    tick("t5_lw0", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive(RS1 | RT1, ALU, 5'd0, 5'd0, 5'd2);
    tick("t5_zero_d", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive(5'b0, NW, 5'd0, 5'd0, 5'd0);
    tick("t5_zero_e", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    flush();

    // lw $4 ; sw $4,0($0): DM result in time for store data
    drive(RS1, DM, 5'd0, 5'd0, 5'd4);
    tick("t7_lw", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive(RS1 | RT2, NW, 5'd0, 5'd4, 5'd0);
    tick("t7_no_stall", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive(5'b0, NW, 5'd0, 5'd0, 5'd0);
    tick("t7_sw_e", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick("t7_sw_m", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    flush();

    // ori $8 ; beq $0,$8: rt-side stall then M forward
    drive(RS1, ALU, 5'd0, 5'd0, 5'd8);
    tick("t8_ori", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive(RS0 | RT0, NW, 5'd0, 5'd8, 5'd0);
    tick("t8_rt_stall", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick("t8_fwd_d_m", 1'b0, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0);
    flush();

    // ori $7 ; ori $7 ; addu $3,$7,$0: M beats W in E
    drive(RS1, ALU, 5'd0, 5'd0, 5'd7);
    tick("t9_ori1", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick("t9_ori2", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive(RS1, ALU, 5'd7, 5'd0, 5'd3);
    tick("t9_addu_d", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive(5'b0, NW, 5'd0, 5'd0, 5'd0);
    tick("t9_m_over_w", 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0);
    flush();

    // ori $1 ; lw $1 ; addu $3,$1,$1 then reset during the stall
    drive(RS1, ALU, 5'd0, 5'd0, 5'd1);
    tick("t6_ori", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive(RS1, DM, 5'd0, 5'd0, 5'd1);
    tick("t6_lw_d", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive(RS1 | RT1, ALU, 5'd1, 5'd1, 5'd3);
    expect_out("t6_shadow", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    check_now();
    reset = 1'b1;
    adv();
    expect_out("t6_reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    check_now();
    reset = 1'b0;
    adv();
    tick("t6_after_reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
